// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants and next-PC source type for the fetch stage
package if_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2
    } next_pc_src_e;

    // A taken branch outranks a simultaneous jump.
    function automatic next_pc_src_e sel_next_pc(input logic pcsrc, input logic jump);
        if (pcsrc) begin
            return BRANCH;
        end else if (jump) begin
            return JUMP;
        end
        return SEQ;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous prefetch FIFO with flush, show-ahead head and count
module if_fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PW + 1)'(DEPTH));
    assign do_pop    = pop && !empty;
    // A full FIFO can still take a push when its head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage (PC, IMEM, prefetch FIFO); FETCH_PERF_EN adds counters
module if_fetch_unit
    import if_fetch_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                IMEM_DEPTH = 256,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] RESET_PC   = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_halt,
    input  logic              i_write_en,
    input  logic [DATA_W-1:0] i_addr_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pcsrc,
    input  logic [DATA_W-1:0] i_beq_dir,
    input  logic              i_jump,
    input  logic [DATA_W-1:0] i_jump_dir,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_instruction,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_pc_plus_4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       o_fetch_cnt,
    output logic [31:0]       o_flush_cnt
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0]   imem [IMEM_DEPTH];
    logic [DATA_W-1:0]   pc;
    logic [DATA_W-1:0]   next_pc;
    logic [DATA_W-1:0]   rd_instr;
    logic [DATA_W-1:0]   rd_pc;
    logic [DATA_W-1:0]   head_instr;
    logic [DATA_W-1:0]   head_pc;
    logic [2*DATA_W-1:0] head_data;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         occupancy;
    logic                fifo_empty;
    logic                inflight;
    logic                redirect;
    logic                issue;
    logic                pop;
    logic                push;
    next_pc_src_e        pc_src;
    logic                unused_low_bits;

    assign unused_low_bits = ^{i_addr_wr[1:0], i_beq_dir[1:0], i_jump_dir[1:0],
                               i_addr_wr[DATA_W-1:AW+2], pc[1:0]};

    assign redirect  = i_pcsrc || i_jump;
    assign pop       = !fifo_empty && i_ready;
    // Entries that will be held once this cycle's pop and in-flight push settle.
    assign occupancy = {1'b0, fifo_count} - (CW + 1)'(pop) + (CW + 1)'(inflight);
    assign issue     = !i_halt && !redirect && (occupancy < (CW + 1)'(FIFO_DEPTH));
    assign push      = inflight && !redirect;

    always_comb begin
        pc_src = sel_next_pc(i_pcsrc, i_jump);
        case (pc_src)
            BRANCH:  next_pc = {i_beq_dir[DATA_W-1:2], 2'b00};
            JUMP:    next_pc = {i_jump_dir[DATA_W-1:2], 2'b00};
            default: next_pc = pc + DATA_W'(PC_STEP);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            rd_pc    <= '0;
        end else begin
            // issue is low during a redirect, so this also kills the in-flight read
            inflight <= issue;
            if (redirect || issue) begin
                pc <= next_pc;
            end
            if (issue) begin
                rd_pc <= pc;
            end
        end
    end

    // Contents survive reset; the debug port writes only while fetch is frozen.
    always_ff @(posedge i_clk) begin
        if (issue) begin
            rd_instr <= imem[pc[AW+1:2]];
        end
        if (i_write_en && i_halt) begin
            imem[i_addr_wr[AW+1:2]] <= i_data;
        end
    end

    if_fetch_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .reset     (i_reset),
        .flush     (redirect),
        .push      (push),
        .push_data ({rd_instr, rd_pc}),
        .pop       (pop),
        .head_data (head_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign head_instr    = head_data[2*DATA_W-1:DATA_W];
    assign head_pc       = head_data[DATA_W-1:0];
    assign o_valid       = !fifo_empty;
    assign o_instruction = fifo_empty ? DATA_W'(NOP_INSTR) : head_instr;
    assign o_pc          = fifo_empty ? '0 : head_pc;
    assign o_pc_plus_4   = fifo_empty ? '0 : head_pc + DATA_W'(PC_STEP);

`ifdef FETCH_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fetch_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (issue) begin
                o_fetch_cnt <= o_fetch_cnt + 32'd1;
            end
            if (redirect && (inflight || !fifo_empty)) begin
                o_flush_cnt <= o_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with a stream-order reference model
module tb_if_fetch_unit;

    localparam int DATA_W     = 32;
    localparam int IMEM_DEPTH = 256;
    localparam int FIFO_DEPTH = 4;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b0;
    logic              i_halt = 1'b1;
    logic              i_write_en = 1'b0;
    logic [DATA_W-1:0] i_addr_wr = '0;
    logic [DATA_W-1:0] i_data = '0;
    logic              i_pcsrc = 1'b0;
    logic [DATA_W-1:0] i_beq_dir = '0;
    logic              i_jump = 1'b0;
    logic [DATA_W-1:0] i_jump_dir = '0;
    logic              i_ready = 1'b0;
    logic              o_valid;
    logic [DATA_W-1:0] o_instruction;
    logic [DATA_W-1:0] o_pc;
    logic [DATA_W-1:0] o_pc_plus_4;
`ifdef FETCH_PERF_EN
    logic [31:0]       o_fetch_cnt;
    logic [31:0]       o_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] mem_model [IMEM_DEPTH];

    if_fetch_unit #(
        .DATA_W     (DATA_W),
        .IMEM_DEPTH (IMEM_DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_halt        (i_halt),
        .i_write_en    (i_write_en),
        .i_addr_wr     (i_addr_wr),
        .i_data        (i_data),
        .i_pcsrc       (i_pcsrc),
        .i_beq_dir     (i_beq_dir),
        .i_jump        (i_jump),
        .i_jump_dir    (i_jump_dir),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_pc_plus_4   (o_pc_plus_4)
`ifdef FETCH_PERF_EN
        ,
        .o_fetch_cnt   (o_fetch_cnt),
        .o_flush_cnt   (o_flush_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Instruction the spec says lives at byte address a (word index wraps modulo depth).
    function automatic logic [DATA_W-1:0] model_instr(input logic [DATA_W-1:0] a);
        return mem_model[(a >> 2) % IMEM_DEPTH];
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_head(input string name, input logic [DATA_W-1:0] exp_pc);
        checks++;
        if (o_valid !== 1'b1 || o_pc !== exp_pc || o_instruction !== model_instr(exp_pc)
            || o_pc_plus_4 !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL %s: got valid=%b pc=%h instr=%h pc4=%h, expected valid=1 pc=%h instr=%h pc4=%h",
                     name, o_valid, o_pc, o_instruction, o_pc_plus_4,
                     exp_pc, model_instr(exp_pc), exp_pc + 32'd4);
        end
    endtask

    task automatic check_invalid(input string name);
        checks++;
        if (o_valid !== 1'b0 || o_pc !== '0 || o_instruction !== '0 || o_pc_plus_4 !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%b pc=%h instr=%h pc4=%h, expected all zero",
                     name, o_valid, o_pc, o_instruction, o_pc_plus_4);
        end
    endtask

    task automatic do_jump(input logic [DATA_W-1:0] target);
        i_jump     = 1'b1;
        i_jump_dir = target;
        step();
        i_jump     = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_halt  = 1'b0;
        i_ready = 1'b1;
        step();
        step();
        check_invalid("reset_outputs");
`ifdef FETCH_PERF_EN
        checks++;
        if (o_fetch_cnt !== 32'd0 || o_flush_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got fetch=%0d flush=%0d, expected 0 and 0", o_fetch_cnt, o_flush_cnt);
        end
`endif
        i_halt  = 1'b1;
        i_reset = 1'b0;
        step();
    endtask

    task automatic test_load();
        i_halt = 1'b1;
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            logic [DATA_W-1:0] w;
            w = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom;
            i_write_en = 1'b1;
            i_addr_wr  = 32'(i * 4) + 32'($urandom_range(0, 3));
            i_data     = w;
            step();
            mem_model[i] = w;
        end
        i_write_en = 1'b0;
    endtask

    task automatic test_stream();
        i_halt  = 1'b1;
        i_ready = 1'b1;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        step();
        i_halt = 1'b0;
        step();
        check_invalid("stream_latency");
        for (int k = 0; k < 8; k++) begin
            step();
            check_head("stream_entry", 32'(k * 4));
        end
    endtask

    task automatic test_backpressure();
        int n;
        i_halt  = 1'b1;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        i_ready = 1'b0;
        i_halt  = 1'b0;
        repeat (10) step();
        check_head("bp_hold_head", 32'h0);
        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check_head("bp_drain_nogap", 32'(k * 4));
            step();
        end
        i_ready = 1'b0;
        repeat (8) step();
        i_halt  = 1'b1;
        i_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (o_valid) begin
                check_head("bp_halt_drain", 32'(40 + n * 4));
                n++;
            end
            step();
        end
        checks++;
        if (n != FIFO_DEPTH) begin
            errors++;
            $display("FAIL bp_buffered_count: got %0d entries, expected %0d", n, FIFO_DEPTH);
        end
        i_halt = 1'b0;
        n = 0;
        while (!o_valid && n < 6) begin
            step();
            n++;
        end
        check_head("bp_resume_pc", 32'd56);
    endtask

    task automatic test_redirect();
        i_ready   = 1'b1;
        i_halt    = 1'b0;
        i_pcsrc   = 1'b1;
        i_beq_dir = 32'h40;
        i_jump    = 1'b1;
        i_jump_dir = 32'h80;
        step();
        i_pcsrc = 1'b0;
        i_jump  = 1'b0;
        check_invalid("redir_gap0");
        step();
        check_invalid("redir_gap1");
        step();
        check_head("branch_wins", 32'h40);
        step();
        check_head("branch_next", 32'h44);
        do_jump(32'h83);
        step();
        step();
        check_head("jump_align", 32'h80);
        do_jump(32'(IMEM_DEPTH * 4 - 8));
        step();
        step();
        check_head("wrap_m2", 32'(IMEM_DEPTH * 4 - 8));
        step();
        check_head("wrap_m1", 32'(IMEM_DEPTH * 4 - 4));
        step();
        check_head("wrap_to_mem0", 32'(IMEM_DEPTH * 4));
    endtask

    task automatic test_debug_write();
        logic [DATA_W-1:0] w;
        i_halt     = 1'b0;
        i_write_en = 1'b1;
        i_addr_wr  = 32'h0;
        i_data     = ~mem_model[0];
        repeat (3) step();
        i_write_en = 1'b0;
        do_jump(32'h0);
        step();
        step();
        check_head("write_ignored_unhalted", 32'h0);
        w          = $urandom;
        i_halt     = 1'b1;
        i_write_en = 1'b1;
        i_addr_wr  = 32'h14;
        i_data     = w;
        do_jump(32'h14);
        i_write_en   = 1'b0;
        mem_model[5] = w;
        i_halt       = 1'b0;
        step();
        step();
        check_head("write_with_redirect", 32'h14);
    endtask

    task automatic test_reset_mid();
        i_halt     = 1'b0;
        i_ready    = 1'b1;
        repeat (5) step();
        i_reset    = 1'b1;
        i_jump     = 1'b1;
        i_jump_dir = 32'h80;
        step();
        i_reset = 1'b0;
        i_jump  = 1'b0;
        check_invalid("reset_mid_flush");
        step();
        check_invalid("reset_mid_latency");
        step();
        check_head("reset_mid_restart", 32'h0);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] exp_pc;
        logic              prev_redir;
        logic              redir;
        int                accepted;
        exp_pc = $urandom;
        do_jump(exp_pc);
        exp_pc     = exp_pc & ~32'h3;
        prev_redir = 1'b1;
        accepted   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (prev_redir) begin
                checks++;
                if (o_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_after_redirect: got valid=%b, expected 0", o_valid);
                end
            end
            if (!o_valid) begin
                check_invalid("rand_empty_zero");
            end
            i_ready = ($urandom_range(0, 9) < 7);
            i_halt  = ($urandom_range(0, 9) == 0);
            redir   = ($urandom_range(0, 24) == 0);
            i_pcsrc = 1'b0;
            i_jump  = 1'b0;
            if (redir) begin
                case ($urandom_range(0, 2))
                    0: i_pcsrc = 1'b1;
                    1: i_jump = 1'b1;
                    default: begin
                        i_pcsrc = 1'b1;
                        i_jump  = 1'b1;
                    end
                endcase
                i_beq_dir  = $urandom;
                i_jump_dir = $urandom;
            end
            if (o_valid && i_ready && !redir) begin
                check_head("rand_stream", exp_pc);
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            if (redir) begin
                exp_pc = (i_pcsrc ? i_beq_dir : i_jump_dir) & ~32'h3;
            end
            prev_redir = redir;
            step();
        end
        i_pcsrc = 1'b0;
        i_jump  = 1'b0;
        checks++;
        if (accepted < 500) begin
            errors++;
            $display("FAIL rand_throughput: got %0d accepted, expected at least 500", accepted);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        int accepted;
        i_halt  = 1'b1;
        i_reset = 1'b1;
        step();
        i_reset  = 1'b0;
        i_halt   = 1'b0;
        accepted = 0;
        for (int k = 0; k < 50; k++) begin
            i_ready = ($urandom_range(0, 1) == 1);
            if (o_valid && i_ready) accepted++;
            step();
        end
        i_halt  = 1'b1;
        i_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (o_valid && i_ready) accepted++;
            step();
        end
        checks++;
        if (o_fetch_cnt !== 32'(accepted)) begin
            errors++;
            $display("FAIL perf_fetch_cnt: got %0d, expected %0d", o_fetch_cnt, accepted);
        end
        i_halt  = 1'b0;
        i_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            repeat (6) step();
            do_jump(32'(r * 16));
        end
        repeat (3) step();
        i_halt  = 1'b1;
        i_ready = 1'b1;
        repeat (8) step();
        do_jump(32'h0);
        checks++;
        if (o_flush_cnt !== 32'd3) begin
            errors++;
            $display("FAIL perf_flush_cnt: got %0d, expected 3", o_flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_stream();
        test_backpressure();
        test_redirect();
        test_debug_write();
        test_reset_mid();
        test_random();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Parametrised next-generation instruction-fetch stage.
- PC register, synchronous instruction memory with a debug load port, and a small prefetch FIFO.
- FIFO decouples fetch from ID through a valid/ready handshake.
- Branch/jump redirects flush in-flight and buffered instructions; debug halt freezes fetch so the debug unit can load the instruction memory.

Parameters:
DATA_W, 32, instruction and PC width
IMEM_DEPTH, 256, instruction memory depth in words (power of 2)
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
RESET_PC, 0, PC value after reset (word aligned)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_halt  in  1  debug halt: no new fetch issued while high
i_write_en  in  1  debug write to instruction memory (honoured only while i_halt=1)
i_addr_wr  in  DATA_W  debug write byte address (bits [1:0] ignored)
i_data  in  DATA_W  debug write data
i_pcsrc  in  1  branch taken redirect
i_beq_dir  in  DATA_W  branch target
i_jump  in  1  jump redirect
i_jump_dir  in  DATA_W  jump target
i_ready  in  1  ID accepts head instruction (ID not stalled)
o_valid  out  1  head instruction valid
o_instruction  out  DATA_W  head instruction
o_pc  out  DATA_W  address of head instruction
o_pc_plus_4  out  DATA_W  o_pc + 4

Behaviour:
- Reset:
  - PC=RESET_PC.
  - FIFO empty; in-flight tag cleared.
  - o_valid=0; o_instruction=0, o_pc=0, o_pc_plus_4=0.
  - Memory contents are not cleared.
- Outputs show the FIFO head. When the FIFO is empty, all data outputs are 0 and o_valid=0.
- Pop occurs on a cycle where o_valid && i_ready.
- Issue condition: !i_halt && (count - pop + inflight) < FIFO_DEPTH, where inflight and pop are 0/1.
- On issue: read IMEM at PC[log2(IMEM_DEPTH)+1:2] and set PC <= PC+4.
  - Address wraps modulo IMEM_DEPTH.
  - PC arithmetic wraps modulo 2^DATA_W.
- IMEM read is registered (1 cycle). The result and its PC are pushed into the FIFO at the next edge.
  - Issue-to-o_valid latency is 2 edges when the FIFO is empty.
  - Sustained throughput: 1 instruction/cycle.
- Redirect (i_pcsrc or i_jump sampled at edge E0):
  - Both high: branch wins.
  - PC <= target with bits [1:0] forced to 0.
  - FIFO cleared and in-flight read killed (not pushed).
  - Any pop in the same cycle is discarded.
  - o_valid=0 after E0; the target instruction is visible with o_valid=1 after E2.
- Halt:
  - Asserting i_halt stops issue only. The in-flight read still completes and pushes.
  - FIFO contents remain poppable.
  - Deasserting i_halt resumes from the current PC.
- Debug write:
  - Writes mem[i_addr_wr index] <= i_data at the edge, only when i_write_en && i_halt.
  - Ignored otherwise.
  - Write and fetch of the same word in the same cycle cannot occur, because no issue happens while halted.
- Redirect and debug write in the same cycle: both take effect.
- Reset mid-operation: identical to power-up reset, and overrides redirect and halt.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds o_fetch_cnt (32 bits, increments per issued read).
  - Adds o_flush_cnt (32 bits, increments per redirect that kills >=1 in-flight or buffered instruction).
  - Both counters reset to 0 and wrap.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package if_fetch_pkg: INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h0, and an enum for the next-PC source (SEQ, BRANCH, JUMP) used by the next-PC mux.
- One sub-module, if_fetch_fifo: synchronous FIFO parametrised by width and depth, with a flush input, push/pop, and count output.

Test Plan:
- Load mem[0..7]=32'h1000_0000+i while halted; release halt with i_ready=1 -> o_valid rises 2 cycles later, then o_instruction=32'h1000_0000..07 on consecutive cycles, o_pc=0,4,...,28, o_pc_plus_4=o_pc+4.
- Hold i_ready=0 -> exactly FIFO_DEPTH=4 entries buffered, PC stalls at 16; raise i_ready -> entries 0..3 drain, then 4.. without gaps or duplicates.
- Assert i_pcsrc=1, i_beq_dir=32'h40 at the same edge as i_jump=1, i_jump_dir=32'h80 -> FIFO flushed, o_valid=0 for 2 cycles, next o_pc=32'h40.
- i_jump with i_jump_dir=32'h83 -> next o_pc=32'h80; PC reaching IMEM_DEPTH*4 -> instruction fetched from mem[0].
- i_write_en=1 with i_halt=0 -> mem unchanged on readback; i_reset pulsed mid-stream -> o_valid=0 next cycle, fetch restarts at RESET_PC.
- With FETCH_PERF_EN defined -> 3 redirects each killing entries give o_flush_cnt=3, and o_fetch_cnt equals the issue count.
